tone_bank: RTL and testbench
============================

TONE_BANK -- requirements
Module: tone_bank

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent tone channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 24, width of the half-period divider in clk cycles.
REQ-003 SHALL have parameter DUR_W, default 16, width of the duration field in half-periods.
REQ-004 SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cfg_valid  input  1  config command present.
REQ-007 SHALL have port cfg_ready  output  1  config accepted when cfg_valid & cfg_ready.
REQ-008 SHALL have port cfg_ch  input  4  target channel index.
REQ-009 SHALL have port cfg_half  input  DIV_W  half-period H in cycles; 0 = stop.
REQ-010 SHALL have port cfg_dur  input  DUR_W  duration D in half-periods; 0 = continuous.
REQ-011 SHALL have port cfg_err  output  1  one-cycle pulse on an accepted command with cfg_ch >= CH.
REQ-012 SHALL have port sw  input  CH  per-channel output gate.
REQ-013 SHALL have port signal  output  CH  per-channel square wave, tone[i] & sw[i].
REQ-014 SHALL have port busy  output  CH  channel i is in the PLAY state.
REQ-015 SHALL have port done  output  CH  one-cycle pulse when a timed tone completes.
REQ-016 SHALL have port mix  output  ceil(log2(CH+1))  count of signal bits currently high.

Function
REQ-017 SHALL drive cfg_ready high in every cycle except while rst is high.
REQ-018 SHALL give each channel a state machine with two states: IDLE (tone=0, counters held at 0) and PLAY.
REQ-019 SHALL, on an accepted command in cycle T with valid cfg_ch and H>=1, enter PLAY at T+1 with cnt=0, tone=0, dur_cnt=0, latching H and D; this applies from either state (restart).
REQ-020 SHALL, on an accepted command in cycle T with H=0, enter IDLE at T+1 with tone=0 and no done pulse.
REQ-021 SHALL, in PLAY, increment cnt each cycle; in a cycle with cnt==H-1, clear cnt and toggle the tone at the next edge (H=1 toggles every cycle).
REQ-022 SHALL, for D>=1, count toggle events in dur_cnt; at the toggle event where dur_cnt==D-1, enter IDLE with tone=0 instead of toggling, and pulse done[i] in the following cycle, giving exactly D half-periods of output.
REQ-023 SHALL, for D=0, play indefinitely; dur_cnt SHALL NOT advance.
REQ-024 SHALL, when cfg_ch>=CH, change no channel state and pulse cfg_err in cycle T+1.
REQ-025 SHALL let a command to a channel win over that channel's terminal toggle in the same cycle: restart per REQ-019/020, no done pulse.
REQ-026 SHALL NOT let sw affect counters, state, busy or done; sw gates signal combinationally only.
REQ-027 SHALL compute mix combinationally as the population count of signal, so that mix never exceeds CH.
REQ-028 SHALL keep channels fully independent; a command to one channel SHALL NOT disturb another.

Reset
REQ-029 SHALL, while rst is high, force all channels to IDLE with cnt=0, dur_cnt=0, tone=0, latched H and D = 0, and busy=0, done=0, cfg_err=0, signal=0, mix=0.
REQ-030 SHALL ignore cfg_valid during reset; rst asserted mid-tone SHALL silence all channels at the next edge, with no done pulse.

Verification (CH=4, DIV_W=8, DUR_W=8)
REQ-031 SHALL verify the reset case: hold rst 2 cycles with cfg_valid=1 -> all outputs 0, cfg_ready=0, and no channel busy afterwards.
REQ-032 SHALL verify continuous play: ch0 H=3 D=0 sw=4'b0001 accepted at T -> signal[0] low T+1..T+3, high T+4..T+6, period 6 indefinitely; mix alternates 0/1; done never pulses.
REQ-033 SHALL verify a timed tone: ch1 H=2 D=4 sw=4'b0010 at T -> signal[1] low/high/low/high for 2 cycles each over T+1..T+8; busy[1]=0 and done[1]=1 at T+9 only.
REQ-034 SHALL verify stop and restart: ch0 playing H=3, then H=0 -> tone 0 next cycle, busy[0]=0, no done; then H=5 while playing -> cnt restarts and the first rise occurs 6 cycles after acceptance.
REQ-035 SHALL verify invalid channel and gating: cfg_ch=5 -> cfg_err pulse at T+1 with no busy change; ch2 H=1 with sw[2]=0 -> busy[2]=1, signal[2]=0, mix excludes ch2.
REQ-036 SHALL verify simultaneous and multi-channel cases: a command at ch1's terminal toggle cycle gives no done and a restart; all 4 channels with H=1 D=0 sw=4'hF -> mix alternates 0 and 4.

Source files
------------

// File: rtl/tone_bank.sv
// Bank of independent square-wave tone generators with per-channel half-period
// divider, optional half-period duration limit, output gating and a live mix count.
module tone_bank #(
  parameter int unsigned CH    = 4,
  parameter int unsigned DIV_W = 24,
  parameter int unsigned DUR_W = 16,
  localparam int unsigned MIX_W = $clog2(CH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_half,
  input  logic [DUR_W-1:0]  cfg_dur,
  output logic              cfg_err,
  input  logic [CH-1:0]     sw,
  output logic [CH-1:0]     signal,
  output logic [CH-1:0]     busy,
  output logic [CH-1:0]     done,
  output logic [MIX_W-1:0]  mix
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_e;

  state_e           state_q [CH];
  state_e           state_d [CH];
  logic [DIV_W-1:0] cnt_q   [CH];
  logic [DIV_W-1:0] cnt_d   [CH];
  logic [DIV_W-1:0] half_q  [CH];
  logic [DIV_W-1:0] half_d  [CH];
  logic [DUR_W-1:0] dcnt_q  [CH];
  logic [DUR_W-1:0] dcnt_d  [CH];
  logic [DUR_W-1:0] dur_q   [CH];
  logic [DUR_W-1:0] dur_d   [CH];
  logic [CH-1:0]    tone_q, tone_d;
  logic [CH-1:0]    done_q, done_d;
  logic             err_q, err_d;

  logic accept_c;
  logic ch_ok_c;

  assign cfg_ready = ~rst;
  assign accept_c  = cfg_valid & cfg_ready;
  assign ch_ok_c   = 32'(cfg_ch) < CH;

  // State register and per-channel datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        half_q[i]  <= '0;
        dcnt_q[i]  <= '0;
        dur_q[i]   <= '0;
      end
      tone_q <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        half_q[i]  <= half_d[i];
        dcnt_q[i]  <= dcnt_d[i];
        dur_q[i]   <= dur_d[i];
      end
      tone_q <= tone_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // Next-state: a command to a channel overrides its own terminal toggle
  always_comb begin
    tone_d = tone_q;
    done_d = '0;
    err_d  = accept_c & ~ch_ok_c;
    for (int unsigned i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      half_d[i]  = half_q[i];
      dcnt_d[i]  = dcnt_q[i];
      dur_d[i]   = dur_q[i];
      if (accept_c && ch_ok_c && (cfg_ch == 4'(i))) begin
        state_d[i] = (cfg_half == '0) ? IDLE : PLAY;
        cnt_d[i]   = '0;
        dcnt_d[i]  = '0;
        tone_d[i]  = 1'b0;
        half_d[i]  = cfg_half;
        dur_d[i]   = cfg_dur;
      end else if (state_q[i] == PLAY) begin
        if (cnt_q[i] == half_q[i] - DIV_W'(1)) begin
          cnt_d[i] = '0;
          if ((dur_q[i] != '0) && (dcnt_q[i] == dur_q[i] - DUR_W'(1))) begin
            state_d[i] = IDLE;
            dcnt_d[i]  = '0;
            tone_d[i]  = 1'b0;
            done_d[i]  = 1'b1;
          end else begin
            tone_d[i] = ~tone_q[i];
            if (dur_q[i] != '0) begin
              dcnt_d[i] = dcnt_q[i] + DUR_W'(1);
            end
          end
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  // Outputs: sw only gates the visible waveform
  always_comb begin
    busy   = '0;
    mix    = '0;
    signal = tone_q & sw;
    for (int unsigned i = 0; i < CH; i++) begin
      busy[i] = (state_q[i] == PLAY);
      mix     = mix + MIX_W'(tone_q[i] & sw[i]);
    end
  end

  assign done    = done_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_tone_bank.sv
// Randomized and directed bench for tone_bank against an elapsed-time model of each channel.
module tb_tone_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_ch;
  logic [7:0] cfg_half;
  logic [7:0] cfg_dur;
  logic       cfg_err;
  logic [3:0] sw;
  logic [3:0] signal;
  logic [3:0] busy;
  logic [3:0] done;
  logic [2:0] mix;

  int checks   = 0;
  int failures = 0;

  tone_bank #(.CH(4), .DIV_W(8), .DUR_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_half(cfg_half), .cfg_dur(cfg_dur), .cfg_err(cfg_err),
    .sw(sw), .signal(signal), .busy(busy), .done(done), .mix(mix)
  );

  always #5 clk = ~clk;

  // Model: each channel remembers when it started; waveform follows from elapsed time
  int m_start [4];
  int m_h     [4];
  int m_d     [4];
  bit m_act   [4];
  int cyc = 0;
  bit err_exp = 1'b0;

  function automatic bit m_busy(int i);
    int e;
    if (!m_act[i]) return 1'b0;
    e = cyc - m_start[i];
    if (m_d[i] != 0 && e >= m_d[i] * m_h[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_tone(int i);
    int e;
    if (!m_busy(i)) return 1'b0;
    e = cyc - m_start[i];
    return ((e / m_h[i]) % 2) == 1;
  endfunction

  function automatic bit m_done(int i);
    return m_act[i] && m_d[i] != 0 && (cyc - m_start[i]) == m_d[i] * m_h[i];
  endfunction

  function automatic logic [15:0] exp_all();
    logic [3:0] s, b, d;
    for (int i = 0; i < 4; i++) begin
      b[i] = m_busy(i);
      s[i] = m_tone(i) & sw[i];
      d[i] = m_done(i);
    end
    return {s, b, d, 3'($countones(s)), err_exp};
  endfunction

  // One clock edge: update model with what the DUT samples, then settle
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) m_act[i] = 1'b0;
      err_exp = 1'b0;
    end else begin
      err_exp = cfg_valid && (cfg_ch >= 4'd4);
      if (cfg_valid && cfg_ch < 4'd4) begin
        if (cfg_half == 8'd0) begin
          m_act[cfg_ch] = 1'b0;
        end else begin
          m_act[cfg_ch]   = 1'b1;
          m_start[cfg_ch] = cyc + 1;
          m_h[cfg_ch]     = int'(cfg_half);
          m_d[cfg_ch]     = int'(cfg_dur);
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic send(input int ch, input int h, input int d);
    cfg_valid = 1'b1;
    cfg_ch    = 4'(ch);
    cfg_half  = 8'(h);
    cfg_dur   = 8'(d);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_half = 8'd3; cfg_dur = 8'd0; sw = 4'hF;
    tick();
    tick();
    checks++;
    if ({signal, busy, done, mix, cfg_err} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0000", {signal, busy, done, mix, cfg_err});
    end
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0", cfg_ready);
    end
    rst = 1'b0; cfg_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 4'h0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_after got busy=%b ready=%b exp busy=0000 ready=1", busy, cfg_ready);
    end
  endtask

  task automatic test_continuous();
    logic [15:0] exp;
    sw = 4'b0001;
    send(0, 3, 0);
    for (int k = 1; k <= 24; k++) begin
      exp = exp_all();
      checks++;
      if ({signal, busy, done, mix, cfg_err} !== exp) begin
        failures++;
        $display("FAIL continuous_model k=%0d got=%h exp=%h", k, {signal, busy, done, mix, cfg_err}, exp);
      end
      checks++;
      if (signal[0] !== 1'(((k - 1) / 3) % 2) || done !== 4'h0) begin
        failures++;
        $display("FAIL continuous_wave k=%0d got sig0=%b done=%b exp sig0=%0d done=0", k, signal[0], done, ((k - 1) / 3) % 2);
      end
      tick();
    end
  endtask

  task automatic test_timed();
    logic [15:0] exp;
    sw = 4'b0011;
    send(1, 2, 4);
    for (int k = 1; k <= 11; k++) begin
      exp = exp_all();
      checks++;
      if ({signal, busy, done, mix, cfg_err} !== exp) begin
        failures++;
        $display("FAIL timed_model k=%0d got=%h exp=%h", k, {signal, busy, done, mix, cfg_err}, exp);
      end
      checks++;
      if (signal[1] !== ((k <= 8) ? 1'(((k - 1) / 2) % 2) : 1'b0) ||
          busy[1] !== (k <= 8) || done[1] !== (k == 9)) begin
        failures++;
        $display("FAIL timed_ch1 k=%0d got sig=%b busy=%b done=%b", k, signal[1], busy[1], done[1]);
      end
      tick();
    end
  endtask

  task automatic test_stop_restart();
    logic [15:0] exp;
    int rise;
    sw = 4'b0001;
    send(0, 0, 0);
    checks++;
    if (busy[0] !== 1'b0 || signal[0] !== 1'b0 || done[0] !== 1'b0) begin
      failures++;
      $display("FAIL stop got busy=%b sig=%b done=%b exp 0 0 0", busy[0], signal[0], done[0]);
    end
    send(0, 3, 0);
    for (int k = 0; k < 4; k++) tick();
    send(0, 5, 0);
    rise = 0;
    for (int k = 1; k <= 20; k++) begin
      if (signal[0] === 1'b1 && rise == 0) rise = k;
      exp = exp_all();
      checks++;
      if ({signal, busy, done, mix, cfg_err} !== exp) begin
        failures++;
        $display("FAIL restart_model k=%0d got=%h exp=%h", k, {signal, busy, done, mix, cfg_err}, exp);
      end
      tick();
    end
    checks++;
    if (rise != 6) begin
      failures++;
      $display("FAIL restart_first_rise got=%0d exp=6", rise);
    end
  endtask

  task automatic test_invalid_gate();
    logic [15:0] exp;
    logic [3:0]  busy_before;
    sw = 4'b1011;
    busy_before = busy;
    send(5, 2, 0);
    checks++;
    if (cfg_err !== 1'b1 || busy !== busy_before) begin
      failures++;
      $display("FAIL invalid_ch got err=%b busy=%b exp err=1 busy=%b", cfg_err, busy, busy_before);
    end
    tick();
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL invalid_pulse got err=%b exp=0", cfg_err);
    end
    send(2, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      exp = exp_all();
      checks++;
      if ({signal, busy, done, mix, cfg_err} !== exp || busy[2] !== 1'b1 || signal[2] !== 1'b0) begin
        failures++;
        $display("FAIL gate k=%0d got=%h exp=%h", k, {signal, busy, done, mix, cfg_err}, exp);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp;
    sw = 4'b0010;
    send(1, 2, 2);
    for (int k = 0; k < 3; k++) tick();
    send(1, 3, 1);
    for (int k = 1; k <= 8; k++) begin
      exp = exp_all();
      checks++;
      if ({signal, busy, done, mix, cfg_err} !== exp) begin
        failures++;
        $display("FAIL simul_model k=%0d got=%h exp=%h", k, {signal, busy, done, mix, cfg_err}, exp);
      end
      if (k == 1) begin
        checks++;
        if (done[1] !== 1'b0 || busy[1] !== 1'b1) begin
          failures++;
          $display("FAIL simul_override got done=%b busy=%b exp done=0 busy=1", done[1], busy[1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_all_channels();
    logic [15:0] exp;
    logic [2:0]  prev;
    sw = 4'hF;
    for (int c = 0; c < 4; c++) begin
      send(c, 1, 0);
      tick();
    end
    prev = mix;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = exp_all();
      checks++;
      if ({signal, busy, done, mix, cfg_err} !== exp || mix !== ((prev == 3'd0) ? 3'd4 : 3'd0)) begin
        failures++;
        $display("FAIL all_mix k=%0d got mix=%0d prev=%0d all=%h exp=%h", k, mix, prev, {signal, busy, done, mix, cfg_err}, exp);
      end
      prev = mix;
    end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 79) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 4'($urandom_range(0, 5));
      cfg_half  = 8'($urandom_range(0, 4));
      cfg_dur   = 8'($urandom_range(0, 3));
      sw        = 4'($urandom);
      tick();
      exp = exp_all();
      checks++;
      if ({signal, busy, done, mix, cfg_err} !== exp || cfg_ready !== ~rst) begin
        failures++;
        $display("FAIL random k=%0d got=%h ready=%b exp=%h", k, {signal, busy, done, mix, cfg_err}, cfg_ready, exp);
      end
    end
    rst = 1'b0; cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 4'd0; cfg_half = 8'd0; cfg_dur = 8'd0; sw = 4'h0;
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 1'b0; m_start[i] = 0; m_h[i] = 1; m_d[i] = 0;
    end
    test_reset();
    test_continuous();
    test_timed();
    test_stop_restart();
    test_invalid_gate();
    test_simultaneous();
    test_all_channels();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
